// File: rtl/tl_arbiter2_if.sv
// TileLink-UL A/D channel bundle with fixed 64-bit address and data.
// A master drives the A channel and d_ready. A slave drives a_ready and the D channel.
interface tilelink;
  logic        a_valid;
  logic        a_ready;
  logic [2:0]  a_opcode;
  logic [2:0]  a_param;
  logic [2:0]  a_size;
  logic [3:0]  a_source;
  logic [63:0] a_address;
  logic [7:0]  a_mask;
  logic [63:0] a_data;

  logic        d_valid;
  logic        d_ready;
  logic [2:0]  d_opcode;
  logic [1:0]  d_param;
  logic [2:0]  d_size;
  logic [3:0]  d_source;
  logic [5:0]  d_sink;
  logic        d_denied;
  logic [63:0] d_data;
  logic        d_corrupt;

  modport master (
    output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, d_ready,
    input  a_ready, d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_data,
           d_corrupt
  );

  modport slave (
    input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, d_ready,
    output a_ready, d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_data,
           d_corrupt
  );
endinterface

// File: rtl/tl_arbiter2.sv
// Round-robin arbiter that lets ifetch (req0) and the LSU (req1) share the MMU virtual port.
// One transaction is outstanding at a time. Page faults go back to the owner as a one-cycle pulse.
module tl_arbiter2 (
  input  logic        clk,
  input  logic        rst_n,
  tilelink.slave      req0_bus,
  tilelink.slave      req1_bus,
  tilelink.master     out_bus,
  input  logic        page_fault,
  input  logic [63:0] tval,
  output logic        fault0,
  output logic        fault1,
  output logic [63:0] fault_tval
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BUSY  = 2'd1,
    S_FAULT = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_q, last_d;
  logic        sent_q, sent_d;
  logic        fault0_q, fault0_d;
  logic        fault1_q, fault1_d;
  logic [63:0] fault_tval_q, fault_tval_d;

  logic busy, sel0, sel1, a_fire, own_d_ready;

  assign busy = (state_q == S_BUSY);
  assign sel0 = busy & ~owner_q;
  assign sel1 = busy &  owner_q;

  // The A channel is shown to the MMU only until it fires once.
  assign out_bus.a_valid   = busy & ~sent_q & (owner_q ? req1_bus.a_valid : req0_bus.a_valid);
  assign out_bus.a_opcode  = sel1 ? req1_bus.a_opcode  : sel0 ? req0_bus.a_opcode  : '0;
  assign out_bus.a_param   = sel1 ? req1_bus.a_param   : sel0 ? req0_bus.a_param   : '0;
  assign out_bus.a_size    = sel1 ? req1_bus.a_size    : sel0 ? req0_bus.a_size    : '0;
  assign out_bus.a_source  = sel1 ? req1_bus.a_source  : sel0 ? req0_bus.a_source  : '0;
  assign out_bus.a_address = sel1 ? req1_bus.a_address : sel0 ? req0_bus.a_address : '0;
  assign out_bus.a_mask    = sel1 ? req1_bus.a_mask    : sel0 ? req0_bus.a_mask    : '0;
  assign out_bus.a_data    = sel1 ? req1_bus.a_data    : sel0 ? req0_bus.a_data    : '0;
  assign out_bus.d_ready   = sel1 ? req1_bus.d_ready   : sel0 ? req0_bus.d_ready   : 1'b0;

  // The owner's a_ready is masked once sent, so a held a_valid never completes a second handshake.
  // A faulting beat is hidden from the owner.
  assign req0_bus.a_ready   = sel0 & ~sent_q & out_bus.a_ready;
  assign req0_bus.d_valid   = sel0 & out_bus.d_valid & ~page_fault;
  assign req0_bus.d_opcode  = sel0 ? out_bus.d_opcode  : '0;
  assign req0_bus.d_param   = sel0 ? out_bus.d_param   : '0;
  assign req0_bus.d_size    = sel0 ? out_bus.d_size    : '0;
  assign req0_bus.d_source  = sel0 ? out_bus.d_source  : '0;
  assign req0_bus.d_sink    = sel0 ? out_bus.d_sink    : '0;
  assign req0_bus.d_denied  = sel0 & out_bus.d_denied;
  assign req0_bus.d_data    = sel0 ? out_bus.d_data    : '0;
  assign req0_bus.d_corrupt = sel0 & out_bus.d_corrupt;

  assign req1_bus.a_ready   = sel1 & ~sent_q & out_bus.a_ready;
  assign req1_bus.d_valid   = sel1 & out_bus.d_valid & ~page_fault;
  assign req1_bus.d_opcode  = sel1 ? out_bus.d_opcode  : '0;
  assign req1_bus.d_param   = sel1 ? out_bus.d_param   : '0;
  assign req1_bus.d_size    = sel1 ? out_bus.d_size    : '0;
  assign req1_bus.d_source  = sel1 ? out_bus.d_source  : '0;
  assign req1_bus.d_sink    = sel1 ? out_bus.d_sink    : '0;
  assign req1_bus.d_denied  = sel1 & out_bus.d_denied;
  assign req1_bus.d_data    = sel1 ? out_bus.d_data    : '0;
  assign req1_bus.d_corrupt = sel1 & out_bus.d_corrupt;

  assign a_fire      = out_bus.a_valid & out_bus.a_ready;
  assign own_d_ready = owner_q ? req1_bus.d_ready : req0_bus.d_ready;

  always_comb begin
    // NOTE: every variable gets a default first, so no path leaves one unassigned (no latch).
    state_d      = state_q;
    owner_d      = owner_q;
    last_d       = last_q;
    sent_d       = sent_q;
    fault0_d     = 1'b0;
    fault1_d     = 1'b0;
    fault_tval_d = fault_tval_q;

    unique case (state_q)
      S_IDLE: begin
        if (req0_bus.a_valid && req1_bus.a_valid) begin
          owner_d = ~last_q;
          state_d = S_BUSY;
        end else if (req0_bus.a_valid) begin
          owner_d = 1'b0;
          state_d = S_BUSY;
        end else if (req1_bus.a_valid) begin
          owner_d = 1'b1;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (a_fire) sent_d = 1'b1;
        if (page_fault) begin
          fault_tval_d = tval;
          fault0_d     = ~owner_q;
          fault1_d     =  owner_q;
          state_d      = S_FAULT;
        end else if (out_bus.d_valid && own_d_ready) begin
          last_d  = owner_q;
          sent_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      S_FAULT: begin
        last_d  = owner_q;
        sent_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      owner_q      <= 1'b0;
      last_q       <= 1'b1;
      sent_q       <= 1'b0;
      fault0_q     <= 1'b0;
      fault1_q     <= 1'b0;
      fault_tval_q <= '0;
    end else begin
      // NOTE: non-blocking assignments here, so every register updates from pre-edge values.
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_q       <= last_d;
      sent_q       <= sent_d;
      fault0_q     <= fault0_d;
      fault1_q     <= fault1_d;
      fault_tval_q <= fault_tval_d;
    end
  end

  assign fault0     = fault0_q;
  assign fault1     = fault1_q;
  assign fault_tval = fault_tval_q;

endmodule

// File: tb/tb_tl_arbiter2.sv
// Directed bench for tl_arbiter2. The bench plays both requesters and the MMU.
// Inputs are driven 1 time unit after posedge. Outputs are sampled on negedge.
module tb_tl_arbiter2;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        page_fault = 1'b0;
  logic [63:0] tval = '0;
  logic        fault0, fault1;
  logic [63:0] fault_tval;

  tilelink r0();
  tilelink r1();
  tilelink mmu();

  always #5 clk = ~clk;

  tl_arbiter2 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_bus   (r0),
    .req1_bus   (r1),
    .out_bus    (mmu),
    .page_fault (page_fault),
    .tval       (tval),
    .fault0     (fault0),
    .fault1     (fault1),
    .fault_tval (fault_tval)
  );

  int n_cmp  = 0;
  int n_err  = 0;
  int n_fire = 0;

  always @(posedge clk) if (rst_n && mmu.a_valid && mmu.a_ready) n_fire++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic await_fire(output logic [3:0] src);
    bit got;
    got = 1'b0;
    src = 4'hf;
    for (int c = 0; c < 8 && !got; c++) begin
      @(negedge clk);
      if (mmu.a_valid && mmu.a_ready) begin
        got = 1'b1;
        src = mmu.a_source;
      end
    end
  endtask

  task automatic beat(input logic [3:0] src);
    mmu.d_valid  = 1'b1;
    mmu.d_source = src;
    mmu.d_data   = {60'h0, src};
  endtask

  logic [3:0] src;
  int         f0;

  initial begin
    r0.a_valid = 0; r0.a_opcode = 3'd4; r0.a_param = 0; r0.a_size = 3'd3;
    r0.a_source = 4'd1; r0.a_address = 64'h8000_0000; r0.a_mask = 8'hff; r0.a_data = 0;
    r0.d_ready = 1;
    r1.a_valid = 0; r1.a_opcode = 3'd4; r1.a_param = 0; r1.a_size = 3'd3;
    r1.a_source = 4'd2; r1.a_address = 64'h9000_0000; r1.a_mask = 8'hff; r1.a_data = 0;
    r1.d_ready = 1;
    mmu.a_ready = 1; mmu.d_valid = 0; mmu.d_opcode = 3'd1; mmu.d_param = 0; mmu.d_size = 3'd3;
    mmu.d_source = 0; mmu.d_sink = 0; mmu.d_denied = 0; mmu.d_data = 0; mmu.d_corrupt = 0;

    // Reset state
    @(negedge clk);
    check("rst_fault0", fault0, 0);
    check("rst_fault1", fault1, 0);
    check("rst_fault_tval", fault_tval, 0);
    check("rst_out_a_valid", mmu.a_valid, 0);
    check("rst_out_d_ready", mmu.d_ready, 0);
    check("rst_out_a_address", mmu.a_address, 0);
    check("rst_r0_a_ready", r0.a_ready, 0);
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;

    // Single request from req0 with a reply three cycles after the fire
    r0.a_valid = 1;
    @(negedge clk);
    check("s1_idle_a_valid", mmu.a_valid, 0);
    check("s1_idle_r0_ready", r0.a_ready, 0);
    next_cycle();
    @(negedge clk);
    check("s1_a_valid", mmu.a_valid, 1);
    check("s1_a_address", mmu.a_address, 64'h8000_0000);
    check("s1_r0_a_ready", r0.a_ready, 1);
    check("s1_r1_a_ready", r1.a_ready, 0);
    next_cycle(); r0.a_valid = 0;
    @(negedge clk);
    check("s1_sent_a_valid", mmu.a_valid, 0);
    check("s1_r1_a_ready_b", r1.a_ready, 0);
    next_cycle();
    @(negedge clk);
    check("s1_no_d_yet", r0.d_valid, 0);
    next_cycle();
    mmu.d_valid = 1; mmu.d_source = 1; mmu.d_data = 64'h1122334455667788;
    @(negedge clk);
    check("s1_r0_d_valid", r0.d_valid, 1);
    check("s1_r0_d_data", r0.d_data, 64'h1122334455667788);
    check("s1_r1_d_valid", r1.d_valid, 0);
    check("s1_r1_d_data", r1.d_data, 0);
    check("s1_r1_a_ready_c", r1.a_ready, 0);
    next_cycle(); mmu.d_valid = 0; mmu.d_data = 0;
    @(negedge clk);
    check("s1_r0_d_done", r0.d_valid, 0);

    // Simultaneous request after reset: req0 first, then req1 after one idle cycle
    do_reset();
    f0 = n_fire;
    r0.a_valid = 1; r1.a_valid = 1;
    @(negedge clk);
    check("s2_idle", mmu.a_valid, 0);
    next_cycle();
    @(negedge clk);
    check("s2_first_src", mmu.a_source, 1);
    check("s2_r0_ready", r0.a_ready, 1);
    check("s2_r1_ready", r1.a_ready, 0);
    next_cycle();
    @(negedge clk);
    check("s2_no_reissue", mmu.a_valid, 0);
    check("s2_r0_ready_masked", r0.a_ready, 0);
    next_cycle(); r0.a_valid = 0; beat(4'd1);
    @(negedge clk);
    check("s2_r0_d_valid", r0.d_valid, 1);
    check("s2_r1_d_valid", r1.d_valid, 0);
    next_cycle(); mmu.d_valid = 0;
    @(negedge clk);
    check("s2_gap", mmu.a_valid, 0);
    next_cycle();
    @(negedge clk);
    check("s2_second_valid", mmu.a_valid, 1);
    check("s2_second_src", mmu.a_source, 2);
    check("s2_r1_ready", r1.a_ready, 1);
    check("s2_r0_ready_b", r0.a_ready, 0);
    next_cycle(); r1.a_valid = 0; beat(4'd2);
    @(negedge clk);
    check("s2_r1_d_valid", r1.d_valid, 1);
    check("s2_r0_d_valid_b", r0.d_valid, 0);
    next_cycle(); mmu.d_valid = 0;
    check("s2_fire_count", n_fire - f0, 2);

    // Fairness: both hold a_valid for six transactions
    f0 = n_fire;
    r0.a_valid = 1; r1.a_valid = 1;
    for (int t = 0; t < 6; t++) begin
      await_fire(src);
      check($sformatf("fair_grant_%0d", t), src, (t % 2 == 0) ? 4'd1 : 4'd2);
      next_cycle(); beat(src);
      @(negedge clk);
      check($sformatf("fair_d_%0d", t), (src == 4'd1) ? r0.d_valid : r1.d_valid, 1);
      next_cycle(); mmu.d_valid = 0;
    end
    r0.a_valid = 0; r1.a_valid = 0;
    check("fair_fire_count", n_fire - f0, 6);
    next_cycle();

    // Page fault while req1 owns the port, with req0 pending
    r1.a_valid = 1;
    next_cycle();
    @(negedge clk);
    check("pf_owner_src", mmu.a_source, 2);
    next_cycle();
    r1.a_valid = 0; r0.a_valid = 1; page_fault = 1; tval = 64'h4000_1000;
    @(negedge clk);
    check("pf_not_yet", fault1, 0);
    next_cycle(); page_fault = 0; tval = 0;
    @(negedge clk);
    check("pf_fault1", fault1, 1);
    check("pf_fault0", fault0, 0);
    check("pf_tval", fault_tval, 64'h4000_1000);
    check("pf_out_idle", mmu.a_valid, 0);
    check("pf_r0_ready", r0.a_ready, 0);
    next_cycle();
    @(negedge clk);
    check("pf_pulse_end", fault1, 0);
    check("pf_idle", mmu.a_valid, 0);
    next_cycle();
    @(negedge clk);
    check("pf_next_valid", mmu.a_valid, 1);
    check("pf_next_src", mmu.a_source, 1);
    next_cycle(); r0.a_valid = 0; beat(4'd1);
    next_cycle(); mmu.d_valid = 0;

    // Fault and D beat in the same cycle: the fault path wins
    r0.a_valid = 1;
    next_cycle();
    @(negedge clk);
    check("fd_grant", mmu.a_valid, 1);
    next_cycle();
    r0.a_valid = 0; page_fault = 1; tval = 64'h5555_0000;
    mmu.d_valid = 1; mmu.d_source = 1; mmu.d_data = 64'hdead;
    @(negedge clk);
    check("fd_d_hidden", r0.d_valid, 0);
    next_cycle(); page_fault = 0; tval = 0; mmu.d_valid = 0; mmu.d_data = 0;
    @(negedge clk);
    check("fd_fault0", fault0, 1);
    check("fd_fault1", fault1, 0);
    check("fd_tval", fault_tval, 64'h5555_0000);
    check("fd_d_after", r0.d_valid, 0);
    next_cycle();
    @(negedge clk);
    check("fd_pulse_end", fault0, 0);
    next_cycle();

    // Asynchronous reset while busy with A already fired
    r1.a_valid = 1;
    next_cycle();
    @(negedge clk);
    check("rm_addr", mmu.a_address, 64'h9000_0000);
    next_cycle(); r1.a_valid = 0;
    @(negedge clk);
    check("rm_busy_d_ready", mmu.d_ready, 1);
    check("rm_busy_tval", fault_tval, 64'h5555_0000);
    #1 rst_n = 1'b0;
    #1;
    check("rm_d_ready", mmu.d_ready, 0);
    check("rm_a_address", mmu.a_address, 0);
    check("rm_fault_tval", fault_tval, 0);
    check("rm_r1_a_ready", r1.a_ready, 0);
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    r0.a_valid = 1; r1.a_valid = 1;
    @(negedge clk);
    check("rm_idle", mmu.a_valid, 0);
    next_cycle();
    @(negedge clk);
    check("rm_tie_src", mmu.a_source, 1);
    check("rm_no_fault0", fault0, 0);
    check("rm_no_fault1", fault1, 0);
    next_cycle(); r0.a_valid = 0; r1.a_valid = 0; beat(4'd1);
    next_cycle(); mmu.d_valid = 0;
    repeat (4) next_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/tl_arbiter2.md
# tl_arbiter2

Two-requester TileLink-UL arbiter that shares the single virtual-address port of the MMU between the instruction-fetch unit and the load/store unit. It sits directly upstream of the MMU's `virt_bus`. It grants one outstanding transaction at a time with round-robin fairness and holds the grant until that transaction's D-channel beat is accepted. It also routes the MMU's `page_fault`/`tval` to the requester that owned the faulting transaction, then releases the grant.

## Interface
- No parameters. Bus widths are fixed by the `tilelink` interface: address and data 64 bits, size 3, source 4, sink 6, mask 8.
- `clk`  in  1  single clock; all state updates on posedge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req0_bus`  tilelink.slave  -  requester 0 (ifetch); wins the first tie after reset.
- `req1_bus`  tilelink.slave  -  requester 1 (LSU).
- `out_bus`  tilelink.master  -  to MMU `virt_bus`.
- `page_fault`  in  1  MMU fault pulse, one cycle.
- `tval`  in  64  MMU faulting virtual address, valid with `page_fault`.
- `fault0`, `fault1`  out  1  registered one-cycle fault pulse to the owning requester.
- `fault_tval`  out  64  registered copy of `tval`, valid with `fault0`/`fault1`.

## Operation
- State register is 2 bits: S_IDLE=0, S_BUSY=1, S_FAULT=2. A 1-bit `owner` register and a 1-bit `last` register hold grant history; `last` resets to 1.
- Both requester A fields are sampled combinationally, on `req0_bus.a_valid`/`req1_bus.a_valid` only.

**S_IDLE**
- `out_bus.a_valid`=0 and `out_bus.d_ready`=0.
- Both requesters see `a_ready`=0 and `d_valid`=0.
- If only reqN `a_valid` is high: `owner`<=N, go to S_BUSY.
- If both are high: `owner`<=~`last`, go to S_BUSY.

**S_BUSY**
- All `out_bus` A-channel fields and `d_ready` are muxed from the owner.
- All owner D-channel fields and `a_ready` come from `out_bus`.
- The non-owner sees `a_ready`=0, `d_valid`=0, and all other D fields 0.
- Once the A channel fires (`a_valid & a_ready`), a `sent` flag is set and `out_bus.a_valid` is forced to 0. This prevents a second issue if the requester keeps `a_valid` high.
- When `out_bus.d_valid & owner d_ready`: `last`<=`owner`, clear `sent`, go to S_IDLE.
- When `page_fault`:
  - `fault_tval`<=`tval`.
  - Pulse `fault<owner>` next cycle.
  - Go to S_FAULT.
  - This has priority over a same-cycle `d_valid`.

**S_FAULT**
- Drives the same as S_IDLE.
- `last`<=`owner`, clear `sent`, then go to S_IDLE unconditionally.

**Requester rules**
- Requesters must hold `a_valid` and the A fields stable until `a_ready`.
- A requester whose `a_valid` drops before grant is simply not selected.

**Reset**
- All outputs 0: `fault0`, `fault1`, `fault_tval`=0, every bus output 0.
- state=S_IDLE, `owner`=0, `last`=1, `sent`=0.
- Reset mid-transaction abandons the transaction with no fault pulse.

## Timing
- Arbitration latency is 1 cycle: a request seen in S_IDLE at edge k is presented on `out_bus` from cycle k+1.
- Minimum gap between back-to-back grants is 1 idle cycle, the return to S_IDLE.
- Fault latency: `page_fault` at edge k produces `faultN`=1 during cycle k+1 only. The next grant is possible at edge k+2.
- At most one transaction is outstanding. There is no D-channel reordering, and `d_source` is passed through unmodified.

## Test plan
- **Single request.** req0 Get at 0x8000_0000; MMU replies `d_data`=0x1122334455667788 after 3 cycles.
  - `out_bus.a_address`=0x8000_0000 the cycle after `a_valid`.
  - req0 receives the data with `d_valid` for one cycle.
  - req1 sees `a_ready`=0 throughout.
- **Simultaneous request after reset.** req0 and req1 assert `a_valid` on the same cycle.
  - req0 is served first.
  - req1 is granted one idle cycle after req0's D beat.
  - Only one `out_bus` A fire per grant.
- **Fairness.** Both requesters hold `a_valid` continuously for 6 transactions → grants alternate 0,1,0,1,0,1.
- **Page fault.** req1 is owner; MMU pulses `page_fault` with `tval`=0x4000_1000 and no `d_valid`.
  - Next cycle: `fault1`=1 and `fault_tval`=0x4000_1000.
  - `fault0`=0.
  - The arbiter returns to idle, and a pending req0 is granted next.
- **Fault and response in the same cycle.** `page_fault` and `d_valid` both assert in one cycle → the fault path is taken and the owner does not see `d_valid`.
- **Reset mid-operation.** `rst_n` is low while S_BUSY with A already fired.
  - All outputs read 0 immediately (asynchronous).
  - After release, the first tie again goes to req0.
